// File: rtl/paddle_position_ctrl.sv
// Paddle position datapath: clamped vertical position, inter-step delay
// timer with a combinational done strobe, and a registered pixel-hit flag
// for the VGA pixel stage.
module paddle_position_ctrl #(
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned X_LEFT       = 16,
    parameter int unsigned STEP         = 4,
    parameter int unsigned Y_RESET      = 208,
    parameter int unsigned DELAY_CYCLES = 500000,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       CLK_100MHz,
    input  logic       Reset,
    input  logic       moveUp,
    input  logic       moveDown,
    input  logic       delay,
    output logic       done,
    output logic [8:0] paddleY,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       paddleOn
);

    localparam logic [9:0]       Y_MAX    = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]       STEP_10  = 10'(STEP);
    localparam logic [9:0]       X_LO     = 10'(X_LEFT);
    localparam logic [9:0]       X_HI     = 10'(X_LEFT + PADDLE_W);
    localparam logic [9:0]       H_10     = 10'(PADDLE_H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [9:0]       y_10;
    logic [9:0]       y_sum;
    logic [8:0]       y_next;
    logic             hit;

    assign y_10  = {1'b0, paddleY};
    assign y_sum = y_10 + STEP_10;

    // Delay interval ends on the cycle the counter reaches its last value.
    assign done = delay & (cnt == CNT_LAST);

    // Next position: one clamped step up or down, hold on conflict or idle.
    always_comb begin
        y_next = paddleY;
        if (moveUp && !moveDown) begin
            y_next = (y_10 < STEP_10) ? '0 : 9'(y_10 - STEP_10);
        end else if (moveDown && !moveUp) begin
            y_next = (y_sum > Y_MAX) ? 9'(Y_MAX) : 9'(y_sum);
        end
    end

    // Pixel hit test against the current (pre-update) paddle position.
    always_comb begin
        hit = (hCount >= X_LO) && (hCount < X_HI) &&
              (vCount >= y_10) && (vCount < y_10 + H_10);
    end

    // Position register.
    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) paddleY <= 9'(Y_RESET);
        else        paddleY <= y_next;
    end

    // Delay counter: runs while delay is high, restarts when it drops or on done.
    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (!delay || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered pixel flag, one cycle behind hCount/vCount.
    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) paddleOn <= 1'b0;
        else        paddleOn <= hit;
    end

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Self-checking bench for paddle_position_ctrl: arithmetic reference model
// checked every cycle, plus directed literal expectations.
module tb_paddle_position_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up = 1'b0, down = 1'b0, dly = 1'b0;
    logic [9:0] h = '0, v = '0;
    logic       done, on;
    logic [8:0] y;

    logic       lo_up = 1'b0, hi_down = 1'b0;
    logic       lo_done, lo_on, hi_done, hi_on;
    logic [8:0] lo_y, hi_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    paddle_position_ctrl #(.DELAY_CYCLES(D), .CNT_W(3)) dut (
        .CLK_100MHz(clk), .Reset(rst_n), .moveUp(up), .moveDown(down),
        .delay(dly), .done(done), .paddleY(y), .hCount(h), .vCount(v),
        .paddleOn(on)
    );

    paddle_position_ctrl #(.DELAY_CYCLES(D), .CNT_W(3), .Y_RESET(2)) u_lo (
        .CLK_100MHz(clk), .Reset(rst_n), .moveUp(lo_up), .moveDown(1'b0),
        .delay(1'b0), .done(lo_done), .paddleY(lo_y), .hCount(10'd0),
        .vCount(10'd0), .paddleOn(lo_on)
    );

    paddle_position_ctrl #(.DELAY_CYCLES(D), .CNT_W(3), .Y_RESET(414)) u_hi (
        .CLK_100MHz(clk), .Reset(rst_n), .moveUp(1'b0), .moveDown(hi_down),
        .delay(1'b0), .done(hi_done), .paddleY(hi_y), .hCount(10'd0),
        .vCount(10'd0), .paddleOn(hi_on)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: position as clamped integer arithmetic, delay as the
    // number of consecutive delay-high cycles modulo D, pixel flag from rules.
    int mY, mRun;
    bit mOn;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mY   <= 208;
            mRun <= 0;
            mOn  <= 1'b0;
        end else begin
            mOn <= (int'(h) >= 16) && (int'(h) < 24) &&
                   (int'(v) >= mY) && (int'(v) < mY + 64);
            if (up && !down)      mY <= (mY < 4) ? 0 : mY - 4;
            else if (down && !up) mY <= (mY + 4 > 416) ? 416 : mY + 4;
            mRun <= dly ? (mRun + 1) % D : 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_paddleY", 32'(y), 32'(mY));
        chk("model_paddleOn", 32'(on), 32'(mOn));
        chk("model_done", 32'(done), 32'(dly && (mRun == D - 1)));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until done is seen (current cycle counts as 1); returns length.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 20) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, t0;
        logic [9:0] th [5] = '{10'd16, 10'd23, 10'd24, 10'd16, 10'd16};
        logic [9:0] tv [5] = '{10'd100, 10'd163, 10'd100, 10'd164, 10'd99};
        logic       te [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        step(2);
        rst_n = 1'b1;
        step(1);
        chk("reset_paddleY", 32'(y), 208);
        chk("reset_done", 32'(done), 0);

        // Clamp at both screen edges.
        lo_up = 1'b1;
        step(1);
        chk("clamp_top_first", 32'(lo_y), 0);
        step(1);
        chk("clamp_top_again", 32'(lo_y), 0);
        lo_up = 1'b0;
        hi_down = 1'b1;
        step(1);
        chk("clamp_bot_first", 32'(hi_y), 416);
        step(1);
        chk("clamp_bot_again", 32'(hi_y), 416);
        hi_down = 1'b0;

        // Reset in the middle of a delay.
        h = 10'd16; v = 10'd210;
        dly = 1'b1;
        step(2);
        chk("pre_reset_on", 32'(on), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_paddleY", 32'(y), 208);
        chk("midreset_paddleOn", 32'(on), 0);
        chk("midreset_done", 32'(done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done(n);
        chk("delay_len_after_reset", 32'(n), 4);
        step(1);
        dly = 1'b0;
        h = '0; v = '0;

        // Single steps and conflicting requests.
        up = 1'b1;
        step(1);
        up = 1'b0;
        chk("move_up", 32'(y), 204);
        down = 1'b1;
        step(1);
        down = 1'b0;
        chk("move_down", 32'(y), 208);
        up = 1'b1; down = 1'b1;
        step(1);
        up = 1'b0; down = 1'b0;
        chk("both_hold", 32'(y), 208);

        // Delay timing: done only in the 4th cycle.
        step(1);
        dly = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("delay_c%0d", i), 32'(done), 32'(i == 4));
            step(1);
        end
        dly = 1'b0;
        step(1);
        dly = 1'b1;
        step(2);
        dly = 1'b0;
        chk("drop_done_low", 32'(done), 0);
        step(1);
        dly = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("restart_c%0d", i), 32'(done), 32'(i == 4));
            step(1);
        end
        dly = 1'b0;

        // Pixel flag at paddleY=100.
        up = 1'b1;
        step(27);
        up = 1'b0;
        chk("y_at_100", 32'(y), 100);
        for (int i = 0; i < 5; i++) begin
            h = th[i]; v = tv[i];
            step(1);
            chk($sformatf("pix_%0d_%0d", th[i], tv[i]), 32'(on), 32'(te[i]));
        end
        h = '0; v = '0;

        // Paired with an emulated paddle FSM holding the up switch.
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 55; s++) begin
            t0 = cyc;
            step(1);
            up = 1'b1;
            step(1);
            up = 1'b0;
            dly = 1'b1;
            wait_done(n);
            step(1);
            dly = 1'b0;
            chk($sformatf("fsm_period_%0d", s), 32'(cyc - t0), 6);
            chk($sformatf("fsm_y_%0d", s), 32'(y),
                32'((208 - 4 * (s + 1)) < 0 ? 0 : 208 - 4 * (s + 1)));
        end
        chk("fsm_final_y", 32'(y), 0);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
